// File: rtl/execution_unit.sv
// -----------------------------------------------------------------------------
// execution_unit
//  LEGv8 execute stage with its main control decoder. Decodes instr[31:21],
//  runs the 64-bit ALU, resolves B/CBZ/CBNZ branches and holds a small
//  doubleword data memory for LDUR/STUR. Writeback is registered.
//
//  Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   pc_i            address of the current instruction
//   instr_i         current instruction
//   rd1_i, rd2_i    register file read data (rd2 source chosen by reg2loc_o)
//   reg2loc_o       1 = rd2 comes from instr[4:0], else instr[20:16]
//   pc_src_o        1 = next PC is branch_addr_o (combinational)
//   branch_addr_o   branch target (combinational)
//   wb_en_o         registered register-write enable
//   wb_reg_o        registered destination register
//   wb_data_o       registered writeback data
// -----------------------------------------------------------------------------
module execution_unit #(
    parameter int unsigned DMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [63:0] rd1_i,
    input  logic [63:0] rd2_i,
    output logic        reg2loc_o,
    output logic        pc_src_o,
    output logic [63:0] branch_addr_o,
    output logic        wb_en_o,
    output logic [4:0]  wb_reg_o,
    output logic [63:0] wb_data_o
);

    localparam int unsigned IDX_W = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {
        FN_ADD = 2'd0,
        FN_SUB = 2'd1,
        FN_AND = 2'd2,
        FN_ORR = 2'd3
    } alu_fn_e;

    logic [10:0] opcode;
    logic        reg2loc, br_b, br_z, br_nz;
    logic        mem_read, mem_to_reg, mem_write, reg_write;
    logic [1:0]  alu_op, alu_src;
    alu_fn_e     alu_fn;

    assign opcode = instr_i[31:21];

    // Main control decoder; unknown opcodes fall through as a NOP
    always_comb begin
        reg2loc    = 1'b0;
        br_b       = 1'b0;
        br_z       = 1'b0;
        br_nz      = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        alu_src    = 2'b00;
        alu_fn     = FN_ADD;
        casez (opcode)
            11'b10001011000: begin reg_write = 1'b1; alu_op = 2'b10; alu_fn = FN_ADD; end
            11'b11001011000: begin reg_write = 1'b1; alu_op = 2'b10; alu_fn = FN_SUB; end
            11'b10001010000: begin reg_write = 1'b1; alu_op = 2'b10; alu_fn = FN_AND; end
            11'b10101010000: begin reg_write = 1'b1; alu_op = 2'b10; alu_fn = FN_ORR; end
            11'b1001000100?: begin
                reg_write = 1'b1; alu_op = 2'b10; alu_src = 2'b10; alu_fn = FN_ADD;
            end
            11'b1101000100?: begin
                reg_write = 1'b1; alu_op = 2'b10; alu_src = 2'b10; alu_fn = FN_SUB;
            end
            11'b11111000010: begin
                mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; alu_src = 2'b01;
            end
            11'b11111000000: begin reg2loc = 1'b1; mem_write = 1'b1; alu_src = 2'b01; end
            11'b10110100???: begin reg2loc = 1'b1; br_z  = 1'b1; alu_op = 2'b01; end
            11'b10110101???: begin reg2loc = 1'b1; br_nz = 1'b1; alu_op = 2'b01; end
            11'b000101?????: begin br_b = 1'b1; end
            default: ;
        endcase
    end

    // Immediates
    logic [63:0] alu_imm, d_off, cb_off, b_off, br_off;
    assign alu_imm = {52'd0, instr_i[21:10]};
    assign d_off   = {{55{instr_i[20]}}, instr_i[20:12]};
    assign cb_off  = {{45{instr_i[23]}}, instr_i[23:5]};
    assign b_off   = {{38{instr_i[25]}}, instr_i[25:0]};

    // Operand B select
    logic [63:0] op_b;
    always_comb begin
        op_b = rd2_i;
        case (alu_src)
            2'b01:   op_b = d_off;
            2'b10:   op_b = alu_imm;
            default: op_b = rd2_i;
        endcase
    end

    // ALU; ALUOp 01 passes operand B so CBZ/CBNZ test the register directly
    logic [63:0] alu_res;
    logic        zero;
    always_comb begin
        alu_res = rd1_i + op_b;
        case (alu_op)
            2'b10: begin
                case (alu_fn)
                    FN_SUB:  alu_res = rd1_i - op_b;
                    FN_AND:  alu_res = rd1_i & op_b;
                    FN_ORR:  alu_res = rd1_i | op_b;
                    default: alu_res = rd1_i + op_b;
                endcase
            end
            2'b01:   alu_res = op_b;
            default: alu_res = rd1_i + op_b;
        endcase
    end
    assign zero = (alu_res == 64'd0);

    // Branch resolution
    assign br_off        = br_b ? b_off : cb_off;
    assign branch_addr_o = pc_i + {br_off[61:0], 2'b00};
    assign pc_src_o      = br_b | (br_z & zero) | (br_nz & ~zero);
    assign reg2loc_o     = reg2loc;

    // Data memory: doubleword indexed, async read, write on rising edge
    logic [63:0]      mem_q [DMEM_DEPTH];
    logic [IDX_W-1:0] mem_idx;
    logic [63:0]      mem_rdata;
    assign mem_idx   = alu_res[IDX_W+2:3];
    assign mem_rdata = mem_read ? mem_q[mem_idx] : 64'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (mem_write) begin
            mem_q[mem_idx] <= rd2_i;
        end
    end

    // Writeback register; writes to XZR are dropped here
    logic        wb_en_d, wb_en_q;
    logic [4:0]  wb_reg_d, wb_reg_q;
    logic [63:0] wb_data_d, wb_data_q;
    assign wb_en_d   = reg_write & (instr_i[4:0] != 5'd31);
    assign wb_reg_d  = instr_i[4:0];
    assign wb_data_d = mem_to_reg ? mem_rdata : alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_reg_q  <= 5'd0;
            wb_data_q <= 64'd0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_en_o   = wb_en_q;
    assign wb_reg_o  = wb_reg_q;
    assign wb_data_o = wb_data_q;

endmodule

// File: tb/tb_execution_unit.sv
// -----------------------------------------------------------------------------
// tb_execution_unit
//  Randomized and directed stimulus for execution_unit, checked against an
//  instruction-level model (mnemonic lookup + plain arithmetic + memory array).
// -----------------------------------------------------------------------------
module tb_execution_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc_i;
    logic [31:0] instr_i;
    logic [63:0] rd1_i, rd2_i;
    logic        reg2loc_o, pc_src_o, wb_en_o;
    logic [63:0] branch_addr_o, wb_data_o;
    logic [4:0]  wb_reg_o;

    execution_unit #(.DMEM_DEPTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .instr_i       (instr_i),
        .rd1_i         (rd1_i),
        .rd2_i         (rd2_i),
        .reg2loc_o     (reg2loc_o),
        .pc_src_o      (pc_src_o),
        .branch_addr_o (branch_addr_o),
        .wb_en_o       (wb_en_o),
        .wb_reg_o      (wb_reg_o),
        .wb_data_o     (wb_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR,
                      K_STUR, K_CBZ, K_CBNZ, K_B, K_NOP} kind_e;

    logic [63:0] mm [32];

    function automatic logic [10:0] kbase(int k);
        case (k)
            0: return 11'b10001011000;  1: return 11'b11001011000;
            2: return 11'b10001010000;  3: return 11'b10101010000;
            4: return 11'b10010001000;  5: return 11'b11010001000;
            6: return 11'b11111000010;  7: return 11'b11111000000;
            8: return 11'b10110100000;  9: return 11'b10110101000;
            10: return 11'b00010100000;
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic [10:0] kmask(int k);
        case (k)
            4, 5:  return 11'b00000000001;
            8, 9:  return 11'b00000000111;
            10:    return 11'b00000011111;
            default: return 11'd0;
        endcase
    endfunction

    function automatic kind_e classify(logic [10:0] op);
        for (int k = 0; k < 11; k++) begin
            if ((op & ~kmask(k)) == kbase(k)) return kind_e'(k);
        end
        return K_NOP;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply an instruction and check the combinational outputs against the model
    task automatic drive(logic [31:0] ins, logic [63:0] pc, logic [63:0] r1, logic [63:0] r2);
        kind_e k;
        logic signed [63:0] off;
        logic [63:0] tgt;
        instr_i = ins; pc_i = pc; rd1_i = r1; rd2_i = r2;
        #1;
        k = classify(ins[31:21]);
        chk("reg2loc", 64'(reg2loc_o), 64'(k == K_STUR || k == K_CBZ || k == K_CBNZ));
        chk("pc_src", 64'(pc_src_o),
            64'(k == K_B || (k == K_CBZ && r2 == 0) || (k == K_CBNZ && r2 != 0)));
        if (k == K_B || k == K_CBZ || k == K_CBNZ) begin
            if (k == K_B) off = $signed(ins[25:0]);
            else          off = $signed(ins[23:5]);
            tgt = pc + off * 4;
            chk("branch_addr", branch_addr_o, tgt);
        end
    endtask

    // Clock the current instruction through and check the writeback
    task automatic clock();
        kind_e k;
        logic [63:0] res, imm, exp_data;
        logic signed [63:0] doff;
        logic wr;
        k    = classify(instr_i[31:21]);
        imm  = {52'd0, instr_i[21:10]};
        doff = $signed(instr_i[20:12]);
        case (k)
            K_ADD:          res = rd1_i + rd2_i;
            K_SUB:          res = rd1_i - rd2_i;
            K_AND:          res = rd1_i & rd2_i;
            K_ORR:          res = rd1_i | rd2_i;
            K_ADDI:         res = rd1_i + imm;
            K_SUBI:         res = rd1_i - imm;
            K_LDUR, K_STUR: res = rd1_i + doff;
            K_CBZ, K_CBNZ:  res = rd2_i;
            default:        res = rd1_i + rd2_i;
        endcase
        wr = (k <= K_LDUR) && (instr_i[4:0] != 5'd31);
        exp_data = (k == K_LDUR) ? mm[res[7:3]] : res;
        if (k == K_STUR) mm[res[7:3]] = rd2_i;
        @(posedge clk);
        #1;
        chk("wb_en", 64'(wb_en_o), 64'(wr));
        chk("wb_reg", 64'(wb_reg_o), 64'(instr_i[4:0]));
        chk("wb_data", wb_data_o, exp_data);
    endtask

    task automatic rand_instr();
        int kk;
        logic [10:0] op;
        logic [20:0] rest;
        logic [63:0] r1, r2;
        kk   = $urandom_range(0, 11);
        rest = 21'($urandom);
        r1   = {$urandom, $urandom};
        r2   = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
        if (kk == 11) begin
            op = 11'($urandom);
            while (classify(op) != K_NOP) op = 11'($urandom);
        end else begin
            op = kbase(kk) | (11'($urandom) & kmask(kk));
        end
        if (kk == 6 || kk == 7) begin
            r1 = 64'($urandom_range(0, 3) * 8);
            rest[20:12] = 9'($urandom_range(0, 7) * 8);
        end
        drive({op, rest}, {$urandom, $urandom}, r1, r2);
        clock();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mm[i] = 64'd0;
        rst_n = 1'b0;
        drive(32'd0, 64'd0, 64'd0, 64'd0);
        chk("rst_wb_en", 64'(wb_en_o), 64'd0);
        chk("rst_wb_reg", 64'(wb_reg_o), 64'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD X3,X1,X2
        drive({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3}, 64'd0, 64'd5, 64'd7);
        clock();
        chk("lit_add_en", 64'(wb_en_o), 64'd1);
        chk("lit_add_reg", 64'(wb_reg_o), 64'd3);
        chk("lit_add_data", wb_data_o, 64'd12);
        // SUBI X4,X1,#1
        drive({10'b1101000100, 12'd1, 5'd1, 5'd4}, 64'd0, 64'd0, 64'd0);
        clock();
        chk("lit_subi_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        // STUR X2,[X1,#8] then LDUR X5,[X1,#8]
        drive({11'b11111000000, 9'd8, 2'b00, 5'd1, 5'd2}, 64'd0, 64'd0, 64'hABCD);
        clock();
        chk("lit_stur_en", 64'(wb_en_o), 64'd0);
        drive({11'b11111000010, 9'd8, 2'b00, 5'd1, 5'd5}, 64'd0, 64'd0, 64'd0);
        clock();
        chk("lit_ldur_data", wb_data_o, 64'hABCD);
        chk("lit_ldur_reg", 64'(wb_reg_o), 64'd5);
        // CBZ taken / not taken
        drive({8'b10110100, 19'd4, 5'd2}, 64'h100, 64'd0, 64'd0);
        chk("lit_cbz_src", 64'(pc_src_o), 64'd1);
        chk("lit_cbz_addr", branch_addr_o, 64'h110);
        clock();
        drive({8'b10110100, 19'd4, 5'd2}, 64'h100, 64'd0, 64'd1);
        chk("lit_cbz_nt", 64'(pc_src_o), 64'd0);
        clock();
        // B -2
        drive({6'b000101, 26'h3FF_FFFE}, 64'h40, 64'd0, 64'd0);
        chk("lit_b_src", 64'(pc_src_o), 64'd1);
        chk("lit_b_addr", branch_addr_o, 64'h38);
        clock();
        // Unknown opcode
        drive(32'h0000_0003, 64'd0, 64'd1, 64'd2);
        chk("lit_nop_src", 64'(pc_src_o), 64'd0);
        clock();
        chk("lit_nop_en", 64'(wb_en_o), 64'd0);
        // ADD to XZR is suppressed
        drive({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd31}, 64'd0, 64'd1, 64'd1);
        clock();
        chk("lit_xzr_en", 64'(wb_en_o), 64'd0);

        for (int n = 0; n < 2000; n++) rand_instr();

        // Asynchronous reset mid-run clears writeback and memory
        drive({11'b11111000000, 9'd16, 2'b00, 5'd1, 5'd2}, 64'd0, 64'd0, 64'h1234);
        clock();
        drive({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd7}, 64'd0, 64'd3, 64'd4);
        clock();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 64'(wb_en_o), 64'd0);
        chk("mid_rst_reg", 64'(wb_reg_o), 64'd0);
        chk("mid_rst_data", wb_data_o, 64'd0);
        for (int i = 0; i < 32; i++) mm[i] = 64'd0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive({11'b11111000010, 9'($urandom), 2'b00, 5'd1, 5'd6}, 64'd0,
                  {$urandom, $urandom}, 64'd0);
            clock();
            chk("post_rst_load", wb_data_o, 64'd0);
        end

        for (int n = 0; n < 500; n++) rand_instr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
